index_match_sched: RTL and testbench
====================================

# index_match_sched

Merge-intersect scheduler for the sparse-multiply index comparison path. Two sorted index streams (nonzero indices of a row of A and a column of B) are consumed, the smaller head is advanced each cycle, and every equal-index pair goes into an internal match FIFO. Each match entry carries the index and both element positions. The downstream multiply-accumulate stage drains the FIFO over a valid/ready handshake.

## Interface
- `IDX_W`, 3: width of a sparse index.
- `POS_W`, 4: width of the element-position counters, which wrap modulo 2^POS_W.
- `DEPTH`, 4: match FIFO depth; must be a power of two, 2 or more.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins an intersection; ignored while `busy`.
- `a_idx`  in  IDX_W  head index of stream A.
- `a_valid`, `a_last`  in  1  A head valid; A head is the final element.
- `a_ready`  out  1  A head consumed this cycle.
- `b_idx`, `b_valid`, `b_last`, `b_ready`: same roles as the A signals, for stream B.
- `m_data`  out  IDX_W+2*POS_W  match entry, packed as {idx, a_pos, b_pos}.
- `m_valid`  out  1  match FIFO not empty.
- `m_ready`  in  1  consumer accepts `m_data`.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `match_count`  out  POS_W+1  matches found in the current or last run.

## Operation
- States: IDLE, RUN, DRAIN_A, DRAIN_B, FLUSH.
- IDLE -> RUN on `start`. On entry, `a_pos`, `b_pos` and `match_count` clear to 0. The FIFO is already empty here.
- RUN, with both heads valid:
  - `a_idx<b_idx`: pop A.
  - `a_idx>b_idx`: pop B.
  - Equal: pop both and push {a_idx, a_pos, b_pos}.
  - An equal pair is popped only if the FIFO can accept it, meaning not full, or full with `m_valid&&m_ready` this cycle. Otherwise neither stream is popped (stall).
  - If either head is invalid, nothing is popped.
- Each pop of A increments `a_pos`; same for B and `b_pos`.
- Stream finish: a pop with `x_last=1` marks that stream finished.
- RUN transitions after a pop:
  - Both streams finished -> FLUSH.
  - Only A finished -> DRAIN_B.
  - Only B finished -> DRAIN_A.
- DRAIN_x: pop x whenever `x_valid`, with no comparison and no push. Popping x with `x_last` -> FLUSH.
- FLUSH: wait until the FIFO is empty, then assert `done` for one cycle and go to IDLE.
- Ready rules:
  - `a_ready`/`b_ready` are combinational from the state, the heads and the FIFO status.
  - They may depend on `x_valid`.
  - They are never asserted in IDLE or FLUSH.
- Producers hold `x_idx`/`x_last` stable while `x_valid && !x_ready`.
- Each stream carries at least one element per run; empty vectors are not supported.

## Timing
- Reset values: `a_ready=b_ready=0`, `m_valid=0`, `m_data=0`, `busy=0`, `done=0`, `match_count=0`. State is IDLE and FIFO pointers are 0.
- Reset asserted mid-run: all state is discarded immediately, no `done` is produced, and FIFO contents are lost.
- Throughput: one comparison decision per cycle in RUN.
- Latency: a push in cycle N appears on `m_valid`/`m_data` at cycle N+1 when the FIFO was empty.
- FIFO is registered, first-word-fall-through. Simultaneous push and pop is allowed at any occupancy, including full.
- `busy` rises in the cycle after `start` and falls in the cycle after `done`.
- `done` asserts in the first FLUSH cycle in which the FIFO is empty. Minimum one cycle after the final pop.
- `start` asserted in the same cycle as `done` is ignored.

## Configuration
- `MATCH_COUNT_EN` defined:
  - `match_count` increments on every push and holds after `done` until the next `start`.
  - It saturates at 2^(POS_W+1)-1.
- `MATCH_COUNT_EN` undefined: the counter logic is removed and `match_count` is tied to 0.

## Test plan
- Basic intersection. A={1,3,5,6}, B={0,3,6,7}, `m_ready=1` -> matches {3,1,1} then {6,3,2}. Then `done`; `match_count=2` with `MATCH_COUNT_EN`.
- Disjoint streams. A={0,2,4}, B={1,3,5} -> no `m_valid`. A finishes first, DRAIN_B consumes index 5, then `done`; `match_count=0`.
- Backpressure. A=B={0,1,2,3,4,5}, `DEPTH=4`, `m_ready=0` -> exactly 4 pairs popped, then stall with `a_ready=b_ready=0`. Raising `m_ready` resumes; all 6 entries arrive in order.
- Bubbles. A={2,7}, B={2,7}, `a_valid` low on alternate cycles -> no pops while a head is invalid. Matches {2,0,0} and {7,1,1}.
- Control edges.
  - `start` while `busy` -> ignored.
  - `rst_n` pulsed low mid-RUN -> outputs return to reset values next edge, no `done`.
  - A new `start` runs a fresh intersection.

Source files
------------

// File: rtl/index_match_sched.sv
// Merge-intersect scheduler: walks two sorted index streams and queues equal-index pairs in a FWFT match FIFO.
// Optional feature: define MATCH_COUNT_EN to keep a saturating count of matches per run.
module index_match_sched #(
  parameter int IDX_W = 3,
  parameter int POS_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [IDX_W-1:0]         a_idx,
  input  logic                     a_valid,
  input  logic                     a_last,
  output logic                     a_ready,
  input  logic [IDX_W-1:0]         b_idx,
  input  logic                     b_valid,
  input  logic                     b_last,
  output logic                     b_ready,
  output logic [IDX_W+2*POS_W-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     busy,
  output logic                     done,
  output logic [POS_W:0]           match_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = IDX_W + 2 * POS_W;
  localparam logic [POS_W-1:0] POS_ONE = 1;
  localparam logic [AW:0]      PTR_ONE = 1;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN_A, DRAIN_B, FLUSH} state_t;

  state_t            state_reg, state_next;
  logic [POS_W-1:0]  a_pos_reg, b_pos_reg;
  logic [AW:0]       wr_ptr_reg, rd_ptr_reg;
  logic [DW-1:0]     mem [DEPTH];
  logic              fifo_empty, fifo_full, fifo_pop, can_push, push, start_run;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign fifo_pop   = m_valid && m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign can_push   = !fifo_full || fifo_pop;
  assign start_run  = (state_reg == IDLE) && start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN: begin
        if ((a_ready && a_last) && (b_ready && b_last)) state_next = FLUSH;
        else if (a_ready && a_last)                     state_next = DRAIN_B;
        else if (b_ready && b_last)                     state_next = DRAIN_A;
      end
      DRAIN_A: if (a_ready && a_last) state_next = FLUSH;
      DRAIN_B: if (b_ready && b_last) state_next = FLUSH;
      FLUSH:   if (fifo_empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    push    = 1'b0;
    busy    = (state_reg != IDLE);
    done    = (state_reg == FLUSH) && fifo_empty;
    case (state_reg)
      RUN: begin
        if (a_valid && b_valid) begin
          if (a_idx < b_idx) begin
            a_ready = 1'b1;
          end else if (a_idx > b_idx) begin
            b_ready = 1'b1;
          end else if (can_push) begin
            a_ready = 1'b1;
            b_ready = 1'b1;
            push    = 1'b1;
          end
        end
      end
      DRAIN_A: a_ready = a_valid;
      DRAIN_B: b_ready = b_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_pos_reg <= '0;
      b_pos_reg <= '0;
    end else if (start_run) begin
      a_pos_reg <= '0;
      b_pos_reg <= '0;
    end else begin
      if (a_ready) a_pos_reg <= a_pos_reg + POS_ONE;
      if (b_ready) b_pos_reg <= b_pos_reg + POS_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push)     wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (fifo_pop) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  // Storage carries no reset; the head is masked while empty so m_data reads 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= {a_idx, a_pos_reg, b_pos_reg};
  end

  assign m_valid = !fifo_empty;
  assign m_data  = m_valid ? mem[rd_ptr_reg[AW-1:0]] : '0;

`ifdef MATCH_COUNT_EN
  localparam logic [POS_W:0] CNT_ONE = 1;
  logic [POS_W:0] match_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  match_count_reg <= '0;
    else if (start_run)                          match_count_reg <= '0;
    else if (push && (match_count_reg != '1))    match_count_reg <= match_count_reg + CNT_ONE;
  end

  assign match_count = match_count_reg;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_index_match_sched.sv
// Directed bench for index_match_sched: a reference intersection fills a scoreboard, DUT matches are popped and compared.
module tb_index_match_sched;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [2:0]  a_idx, b_idx;
  logic        a_valid, a_last, a_ready;
  logic        b_valid, b_last, b_ready;
  logic [10:0] m_data;
  logic        m_valid, m_ready;
  logic        busy, done;
  logic [4:0]  match_count;

  index_match_sched #(.IDX_W(3), .POS_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_idx(a_idx), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
    .b_idx(b_idx), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .match_count(match_count)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          a_arr [8];
  int          b_arr [8];
  int          a_n, b_n, a_i, b_i, cyc, n_match;
  bit          done_seen;
  logic [10:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_count(input int n);
`ifdef MATCH_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // Reference model: brute-force intersection by position, independent of merge order.
  task automatic build_sb();
    sb.delete();
    n_match = 0;
    for (int i = 0; i < a_n; i++)
      for (int j = 0; j < b_n; j++)
        if (a_arr[i] == b_arr[j]) begin
          sb.push_back({3'(a_arr[i]), 4'(i), 4'(j)});
          n_match++;
        end
  endtask

  task automatic step(input bit bub, input bit mr, input bit st);
    logic [10:0] exp;
    @(negedge clk);
    cyc++;
    start   = st;
    m_ready = mr;
    a_valid = (a_i < a_n) && !(bub && (cyc % 2 == 1));
    a_idx   = 3'(a_arr[a_i % 8]);
    a_last  = (a_i == a_n - 1);
    b_valid = (b_i < b_n);
    b_idx   = 3'(b_arr[b_i % 8]);
    b_last  = (b_i == b_n - 1);
    #1;
    if (done) done_seen = 1'b1;
    if (bub && !a_valid) chk("bubble_no_pop", {a_ready, b_ready}, 2'b00);
    if (m_valid && m_ready) begin
      if (sb.size() == 0) chk("sb_underflow", m_valid, 1'b0);
      else begin
        exp = sb.pop_front();
        chk("m_data", m_data, exp);
        $display("[TB] match idx=%0d a_pos=%0d b_pos=%0d", m_data[10:8], m_data[7:4], m_data[3:0]);
      end
    end
    if (a_valid && a_ready) a_i++;
    if (b_valid && b_ready) b_i++;
  endtask

  task automatic run(input string name, input bit bub, input bit spurious, input int hold, input int stall_pops);
    done_seen = 1'b0;
    cyc = 0;
    a_i = 0;
    b_i = 0;
    build_sb();
    step(bub, hold == 0, 1'b1);
    @(posedge clk);
    #1;
    chk({name, "_busy_rise"}, busy, 1'b1);
    while (!done_seen && cyc < 200) begin
      step(bub, cyc >= hold, spurious && (cyc == 3));
      if (hold > 0 && cyc == hold - 1) begin
        chk({name, "_stall_a_pops"}, a_i, stall_pops);
        chk({name, "_stall_b_pops"}, b_i, stall_pops);
        chk({name, "_stall_ready"}, {a_ready, b_ready}, 2'b00);
      end
    end
    chk({name, "_done_seen"}, done_seen, 1'b1);
    chk({name, "_sb_empty"}, sb.size(), 0);
    chk({name, "_a_consumed"}, a_i, a_n);
    chk({name, "_b_consumed"}, b_i, b_n);
    chk({name, "_match_count"}, match_count, exp_count(n_match));
    step(1'b0, 1'b1, 1'b0);
    chk({name, "_busy_fall"}, busy, 1'b0);
    chk({name, "_done_pulse"}, done, 1'b0);
    chk({name, "_count_hold"}, match_count, exp_count(n_match));
    $display("[TB] run %s: %0d matches, %0d cycles", name, n_match, cyc);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; m_ready = 1'b0;
    a_idx = '0; a_valid = 1'b0; a_last = 1'b0;
    b_idx = '0; b_valid = 1'b0; b_last = 1'b0;
    a_n = 0; b_n = 0; a_i = 0; b_i = 0;
    #1;
    chk("rst_ready", {a_ready, b_ready}, 2'b00);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 11'd0);
    chk("rst_busy_done", {busy, done}, 2'b00);
    chk("rst_match_count", match_count, 5'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    a_arr = '{1, 3, 5, 6, 0, 0, 0, 0}; a_n = 4;
    b_arr = '{0, 3, 6, 7, 0, 0, 0, 0}; b_n = 4;
    run("basic", 1'b0, 1'b1, 0, 0);

    a_arr = '{0, 2, 4, 0, 0, 0, 0, 0}; a_n = 3;
    b_arr = '{1, 3, 5, 0, 0, 0, 0, 0}; b_n = 3;
    run("disjoint", 1'b0, 1'b0, 0, 0);

    a_arr = '{0, 1, 2, 3, 4, 5, 0, 0}; a_n = 6;
    b_arr = '{0, 1, 2, 3, 4, 5, 0, 0}; b_n = 6;
    run("backpressure", 1'b0, 1'b0, 12, 4);

    a_arr = '{2, 7, 0, 0, 0, 0, 0, 0}; a_n = 2;
    b_arr = '{2, 7, 0, 0, 0, 0, 0, 0}; b_n = 2;
    run("bubbles", 1'b1, 1'b0, 0, 0);

    // Reset in the middle of a run discards everything.
    a_arr = '{0, 1, 2, 3, 4, 5, 0, 0}; a_n = 6;
    b_arr = '{0, 1, 2, 3, 4, 5, 0, 0}; b_n = 6;
    cyc = 0; a_i = 0; b_i = 0; done_seen = 1'b0;
    build_sb();
    step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {a_ready, b_ready}, 2'b00);
    chk("midrst_m_valid", m_valid, 1'b0);
    chk("midrst_m_data", m_data, 11'd0);
    chk("midrst_busy_done", {busy, done}, 2'b00);
    chk("midrst_match_count", match_count, 5'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      step(1'b0, 1'b1, 1'b0);
      chk("postrst_idle", {busy, done, m_valid}, 3'b000);
    end
    chk("postrst_no_done", done_seen, 1'b0);

    a_arr = '{1, 3, 5, 6, 0, 0, 0, 0}; a_n = 4;
    b_arr = '{0, 3, 6, 7, 0, 0, 0, 0}; b_n = 4;
    run("fresh", 1'b0, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
